// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
// Groups the fetch-stage control bus between the fetch sequencing controller
// and its neighbours (program_counter, hazard unit, EX redirect, pipeline regs).
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   pc_i              in   XLEN  current PC from program_counter
//   stall_i           in   1     load-use stall request
//   freeze_i          in   1     global freeze of the front end
//   redirect_valid_i  in   1     EX resolved a taken branch/jump
//   redirect_target_i in   XLEN  redirect target PC
//   halt_i            in   1     halt request
//   resume_i          in   1     leave HALT
//   pc_we_o           out  1     program_counter write enable
//   pc_next_o         out  XLEN  next PC
//   ifid_we_o         out  1     IF/ID register enable
//   ifid_flush_o      out  1     IF/ID bubble insert
//   idex_flush_o      out  1     ID/EX bubble insert
//   misaligned_o      out  1     misaligned redirect pulse
//   state_o           out  2     BOOT=0, RUN=1, HALT=2
//   fetch_count_o     out  32    PC advances made in RUN
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_i;
  logic            stall_i;
  logic            freeze_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_target_i;
  logic            halt_i;
  logic            resume_i;
  logic            pc_we_o;
  logic [XLEN-1:0] pc_next_o;
  logic            ifid_we_o;
  logic            ifid_flush_o;
  logic            idex_flush_o;
  logic            misaligned_o;
  logic [1:0]      state_o;
  logic [31:0]     fetch_count_o;

  // Driven by the surrounding core (or a testbench).
  modport master (
    output pc_i, stall_i, freeze_i, redirect_valid_i, redirect_target_i,
           halt_i, resume_i,
    input  pc_we_o, pc_next_o, ifid_we_o, ifid_flush_o, idex_flush_o,
           misaligned_o, state_o, fetch_count_o
  );

  // Used by the fetch controller itself.
  modport slave (
    input  pc_i, stall_i, freeze_i, redirect_valid_i, redirect_target_i,
           halt_i, resume_i,
    output pc_we_o, pc_next_o, ifid_we_o, ifid_flush_o, idex_flush_o,
           misaligned_o, state_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Cycle-by-cycle sequencing of the instruction-fetch stage. Chooses between
// sequential fetch, EX redirects, load-use stalls, global freezes and halts,
// and drives the PC write enable / next PC plus IF/ID and ID/EX enables and
// flushes. Holds a post-reset BOOT window and a HALT state with resume.
//
// Ports:
//   clk    in  core clock, rising-edge
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_ctrl_if.slave, see fetch_ctrl_if.sv for the signal list
//
// Parameters:
//   XLEN        PC width (must match the interface)
//   RESET_PC    PC value driven while not fetching from a live PC
//   BOOT_CYCLES cycles spent in BOOT after reset release (1..255)
module fetch_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BOOT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [7:0]      boot_cnt_q, boot_cnt_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [31:0]     fetch_count_q;

  logic            pc_we;
  logic [XLEN-1:0] pc_next;
  logic            ifid_we;
  logic            ifid_flush;
  logic            idex_flush;
  logic            misaligned;

  // A live redirect always beats one parked during a freeze, since the live
  // one comes from a younger branch resolution.
  logic            eff_valid;
  logic [XLEN-1:0] eff_target;

  assign eff_valid  = bus.redirect_valid_i | pend_valid_q;
  assign eff_target = bus.redirect_valid_i ? bus.redirect_target_i : pend_target_q;

  // State, boot counter, parked redirect and fetch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if (pc_we) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  // Next-state and Mealy outputs. In RUN the priority chain is
  // halt > misaligned redirect > freeze > redirect > stall > sequential.
  // A redirect overrides a stall because the stalled instruction is on the
  // wrong path anyway.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pc_we         = 1'b0;
    pc_next       = RESET_PC;
    ifid_we       = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    misaligned    = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.halt_i) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = ST_HALT;
        end else if (eff_valid && (eff_target[1:0] != 2'b00)) begin
          misaligned   = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = ST_HALT;
        end else if (bus.freeze_i) begin
          // Park the newest redirect so it is applied once the freeze lifts.
          if (bus.redirect_valid_i) begin
            pend_valid_d  = 1'b1;
            pend_target_d = bus.redirect_target_i;
          end
        end else if (eff_valid) begin
          pc_we        = 1'b1;
          pc_next      = eff_target;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          pend_valid_d = 1'b0;
        end else if (bus.stall_i) begin
          idex_flush = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          pc_next = bus.pc_i + XLEN'(4);
        end
      end

      ST_HALT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (bus.resume_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.pc_we_o       = pc_we;
  assign bus.pc_next_o     = pc_next;
  assign bus.ifid_we_o     = ifid_we;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_flush_o  = idex_flush;
  assign bus.misaligned_o  = misaligned;
  assign bus.state_o       = state_q;
  assign bus.fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl (BOOT_CYCLES=4, RESET_PC=0). Each cycle
// the stimulus task drives the inputs and pushes the expected outputs onto a
// scoreboard queue; the entry is popped and compared once the combinational
// outputs have settled, well before the next rising edge.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;

  fetch_ctrl_if #(.XLEN(32)) bus ();

  fetch_ctrl #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .BOOT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        mis;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          assert_count = 0;
  int          fail_count   = 0;
  logic [31:0] exp_count    = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, then pop and
  // compare after settling. Ends on the following falling edge. The expected
  // fetch count is the registered value, so it advances only after a cycle
  // that expects pc_we=1.
  task automatic applyStimulus(
    input string tag,
    input logic [31:0] pc, input logic stall, input logic freeze,
    input logic rv, input logic [31:0] tgt, input logic halt, input logic resume,
    input logic e_we, input logic [31:0] e_next, input logic e_ifwe,
    input logic e_iff, input logic e_idf, input logic e_mis, input logic [1:0] e_st);
    exp_t e;
    exp_t got;
    bus.pc_i              = pc;
    bus.stall_i           = stall;
    bus.freeze_i          = freeze;
    bus.redirect_valid_i  = rv;
    bus.redirect_target_i = tgt;
    bus.halt_i            = halt;
    bus.resume_i          = resume;
    e.tag = tag; e.pc_we = e_we; e.pc_next = e_next; e.ifid_we = e_ifwe;
    e.ifid_flush = e_iff; e.idex_flush = e_idf; e.mis = e_mis; e.st = e_st;
    e.cnt = exp_count;
    sb.push_back(e);
    if (e_we) exp_count = exp_count + 32'd1;
    #2;
    got = sb.pop_front();
    checkOutput({got.tag, ".pc_we"},      32'(bus.pc_we_o),      32'(got.pc_we));
    checkOutput({got.tag, ".pc_next"},    bus.pc_next_o,         got.pc_next);
    checkOutput({got.tag, ".ifid_we"},    32'(bus.ifid_we_o),    32'(got.ifid_we));
    checkOutput({got.tag, ".ifid_flush"}, 32'(bus.ifid_flush_o), 32'(got.ifid_flush));
    checkOutput({got.tag, ".idex_flush"}, 32'(bus.idex_flush_o), 32'(got.idex_flush));
    checkOutput({got.tag, ".misaligned"}, 32'(bus.misaligned_o), 32'(got.mis));
    checkOutput({got.tag, ".state"},      32'(bus.state_o),      32'(got.st));
    checkOutput({got.tag, ".fetch_count"}, bus.fetch_count_o,    got.cnt);
    @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.pc_i = '0; bus.stall_i = 0; bus.freeze_i = 0; bus.redirect_valid_i = 0;
    bus.redirect_target_i = '0; bus.halt_i = 0; bus.resume_i = 0;
    @(negedge clk);

    //            tag          pc            stl frz rv  tgt           hlt res  we  next          ifwe iff idf mis st
    applyStimulus("reset0",    32'h0,        0,  0,  0,  32'h0,        0,  0,   0,  32'h0,        0,   1,  1,  0,  2'd0);
    applyStimulus("reset1",    32'h0,        0,  0,  0,  32'h0,        0,  0,   0,  32'h0,        0,   1,  1,  0,  2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus("boot",    32'h0,        0,  0,  0,  32'h0,        0,  0,   0,  32'h0,        0,   1,  1,  0,  2'd0);
    applyStimulus("run_first", 32'h0,        0,  0,  0,  32'h0,        0,  0,   1,  32'h4,        1,   0,  0,  0,  2'd1);

    applyStimulus("stall",     32'h100,      1,  0,  0,  32'h0,        0,  0,   0,  32'h0,        0,   0,  1,  0,  2'd1);
    applyStimulus("stall_rd",  32'h100,      1,  0,  1,  32'h200,      0,  0,   1,  32'h200,      0,   1,  1,  0,  2'd1);
    applyStimulus("seq_200",   32'h200,      0,  0,  0,  32'h0,        0,  0,   1,  32'h204,      1,   0,  0,  0,  2'd1);

    applyStimulus("frz_rd300", 32'h204,      0,  1,  1,  32'h300,      0,  0,   0,  32'h0,        0,   0,  0,  0,  2'd1);
    applyStimulus("frz_idle",  32'h204,      0,  1,  0,  32'h0,        0,  0,   0,  32'h0,        0,   0,  0,  0,  2'd1);
    applyStimulus("frz_rd340", 32'h204,      0,  1,  1,  32'h340,      0,  0,   0,  32'h0,        0,   0,  0,  0,  2'd1);
    applyStimulus("unfrz_pend",32'h204,      0,  0,  0,  32'h0,        0,  0,   1,  32'h340,      0,   1,  1,  0,  2'd1);
    applyStimulus("pend_empty",32'h340,      0,  0,  0,  32'h0,        0,  0,   1,  32'h344,      1,   0,  0,  0,  2'd1);

    applyStimulus("frz_rd500", 32'h344,      0,  1,  1,  32'h500,      0,  0,   0,  32'h0,        0,   0,  0,  0,  2'd1);
    applyStimulus("live_wins", 32'h344,      0,  0,  1,  32'h600,      0,  0,   1,  32'h600,      0,   1,  1,  0,  2'd1);
    applyStimulus("seq_600",   32'h600,      0,  0,  0,  32'h0,        0,  0,   1,  32'h604,      1,   0,  0,  0,  2'd1);

    applyStimulus("wrap",      32'hFFFF_FFFC,0,  0,  0,  32'h0,        0,  0,   1,  32'h0,        1,   0,  0,  0,  2'd1);
    applyStimulus("after_wrap",32'h0,        0,  0,  0,  32'h0,        0,  0,   1,  32'h4,        1,   0,  0,  0,  2'd1);

    applyStimulus("halt_rd",   32'h4,        0,  0,  1,  32'h400,      1,  0,   0,  32'h0,        0,   1,  1,  0,  2'd1);
    applyStimulus("halt_hold", 32'h4,        0,  0,  1,  32'h400,      1,  0,   0,  32'h0,        0,   1,  1,  0,  2'd2);
    applyStimulus("resume_hlt",32'h4,        0,  0,  0,  32'h0,        1,  1,   0,  32'h0,        0,   1,  1,  0,  2'd2);
    applyStimulus("resumed",   32'h4,        0,  0,  0,  32'h0,        0,  0,   1,  32'h8,        1,   0,  0,  0,  2'd1);

    applyStimulus("misalign",  32'h8,        0,  0,  1,  32'h102,      0,  0,   0,  32'h0,        0,   1,  1,  1,  2'd1);
    applyStimulus("mis_halt",  32'h8,        0,  0,  0,  32'h0,        0,  0,   0,  32'h0,        0,   1,  1,  0,  2'd2);
    applyStimulus("mis_resume",32'h8,        0,  0,  0,  32'h0,        0,  1,   0,  32'h0,        0,   1,  1,  0,  2'd2);
    applyStimulus("mis_run",   32'h8,        0,  0,  0,  32'h0,        0,  0,   1,  32'hC,        1,   0,  0,  0,  2'd1);

    applyStimulus("frz_rd700", 32'hC,        0,  1,  1,  32'h700,      0,  0,   0,  32'h0,        0,   0,  0,  0,  2'd1);
    rst_n = 1'b0;
    exp_count = 0;
    applyStimulus("rst_frz",   32'hC,        0,  1,  0,  32'h0,        0,  0,   0,  32'h0,        0,   1,  1,  0,  2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus("reboot",  32'h0,        0,  0,  0,  32'h0,        0,  0,   0,  32'h0,        0,   1,  1,  0,  2'd0);
    applyStimulus("no_stale",  32'h0,        0,  0,  0,  32'h0,        0,  0,   1,  32'h4,        1,   0,  0,  0,  2'd1);
    applyStimulus("cnt_after", 32'h4,        0,  0,  0,  32'h0,        0,  0,   1,  32'h8,        1,   0,  0,  0,  2'd1);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
